sd_clk_switch_ctrl: RTL and testbench

Sequences the SD card clock: after reset, runs the card power-up clock burst at 400 kHz, then performs glitch-free speed changes between 400 kHz and 10 MHz on host request. It drives the select input of the SD clock mux and a clock-enable that gates the mux output to the SD pin. Changes are made only while the SD bus is idle, and the gate only opens or closes while the clock is low. Runs entirely in the 250 MHz PLL domain.

---
 rtl/sd_clk_switch_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_sd_clk_switch_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_clk_switch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sd_clk_switch_ctrl
// Purpose  : SD card clock sequencer. Runs the power-up clock burst at the
//            slow rate, then performs glitch-free 400 kHz <-> 10 MHz switches
//            on host request. The mux select only moves while the pin gate is
//            closed, and the gate only opens or closes while the clock is low.
// Revision : 1.0 - initial release
// ============================================================================
module sd_clk_switch_ctrl #(
  parameter int INIT_EDGES    = 80,
  parameter int STOP_CYCLES   = 64,
  parameter int SETTLE_CYCLES = 64,
  parameter int BUSY_TIMEOUT  = 1048576,
  parameter int CW            = 20
) (
  input  logic pll0_250MHz,
  input  logic reset,
  input  logic SDLocalClk,
  input  logic SDBusy,
  input  logic SpeedReq,
  input  logic SpeedSel,
  output logic SDClkSelect,
  output logic SDClkEnable,
  output logic InitDone,
  output logic SpeedAck,
  output logic SpeedErr,
  output logic CtrlBusy
);

  // Targets are one bit wider than the counter so that a limit equal to
  // 2**CW (the default busy timeout) is still reachable by counter+1.
  localparam logic [CW:0] C_INIT_EDGES    = (CW+1)'(INIT_EDGES);
  localparam logic [CW:0] C_STOP_CYCLES   = (CW+1)'(STOP_CYCLES);
  localparam logic [CW:0] C_SETTLE_CYCLES = (CW+1)'(SETTLE_CYCLES);
  localparam logic [CW:0] C_BUSY_TIMEOUT  = (CW+1)'(BUSY_TIMEOUT);

  typedef enum logic [3:0] {
    S_INIT_GATE  = 4'd0,
    S_INIT_RUN   = 4'd1,
    S_INIT_STOP  = 4'd2,
    S_IDLE       = 4'd3,
    S_WAIT_IDLE  = 4'd4,
    S_GATE       = 4'd5,
    S_STOP_WAIT  = 4'd6,
    S_SETTLE     = 4'd7,
    S_UNGATE     = 4'd8,
    S_ACK        = 4'd9,
    S_HOLD       = 4'd10
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            clk_d_q;
  logic            sel_q, sel_d;
  logic            en_q, en_d;
  logic            done_q, done_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic            cap_sel_q, cap_sel_d;
  logic            cap_en_q, cap_en_d;

  logic            rise;
  logic            low_now;
  logic [CW:0]     cnt_inc;
  logic [CW-1:0]   cnt_sat;

  assign rise    = SDLocalClk & ~clk_d_q;
  assign low_now = ~SDLocalClk;
  assign cnt_inc = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};
  // Counter holds at all-ones rather than wrapping.
  assign cnt_sat = (&cnt_q) ? cnt_q : cnt_inc[CW-1:0];

  // Next-state and registered-output decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    en_d      = en_q;
    done_d    = done_q;
    cap_sel_d = cap_sel_q;
    cap_en_d  = cap_en_q;
    err_d     = 1'b0;
    case (state_q)
      S_INIT_GATE: begin
        if (low_now) begin
          en_d    = 1'b1;
          cnt_d   = '0;
          state_d = S_INIT_RUN;
        end
      end
      S_INIT_RUN: begin
        if (rise) begin
          cnt_d = cnt_sat;
          if (cnt_inc == C_INIT_EDGES) state_d = S_INIT_STOP;
        end
      end
      S_INIT_STOP: begin
        if (low_now) begin
          en_d    = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (SpeedReq && done_q) begin
          if (SpeedSel == sel_q) begin
            state_d = S_ACK;
          end else begin
            state_d   = S_WAIT_IDLE;
            cnt_d     = '0;
            cap_sel_d = SpeedSel;
            cap_en_d  = en_q;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (!SDBusy) begin
          state_d = S_GATE;
        end else begin
          cnt_d = cnt_sat;
          if (cnt_inc == C_BUSY_TIMEOUT) begin
            err_d   = 1'b1;
            state_d = S_HOLD;
          end
        end
      end
      S_GATE: begin
        // Closing only on a low phase avoids a runt high pulse at the pin.
        if (low_now) begin
          en_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_STOP_WAIT;
        end
      end
      S_STOP_WAIT: begin
        if (cnt_inc == C_STOP_CYCLES) begin
          sel_d   = cap_sel_q;
          cnt_d   = '0;
          state_d = S_SETTLE;
        end else begin
          cnt_d = cnt_sat;
        end
      end
      S_SETTLE: begin
        if (cnt_inc == C_SETTLE_CYCLES) state_d = S_UNGATE;
        else                            cnt_d   = cnt_sat;
      end
      S_UNGATE: begin
        if (low_now) begin
          en_d    = cap_en_q;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        state_d = S_HOLD;
      end
      S_HOLD: begin
        // Wait for the host to drop the request so it is not serviced twice.
        if (!SpeedReq) state_d = S_IDLE;
      end
      default: begin
        state_d = S_INIT_GATE;
      end
    endcase
    ack_d  = (state_d == S_ACK);
    busy_d = (state_d != S_IDLE);
  end

  // Edge-detect history; needs no reset since INIT_GATE ignores it.
  always_ff @(posedge pll0_250MHz) begin
    clk_d_q <= SDLocalClk;
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge pll0_250MHz) begin
    if (reset) begin
      state_q   <= S_INIT_GATE;
      cnt_q     <= '0;
      sel_q     <= 1'b0;
      en_q      <= 1'b0;
      done_q    <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b1;
      cap_sel_q <= 1'b0;
      cap_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      en_q      <= en_d;
      done_q    <= done_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      cap_sel_q <= cap_sel_d;
      cap_en_q  <= cap_en_d;
    end
  end

  assign SDClkSelect = sel_q;
  assign SDClkEnable = en_q;
  assign InitDone    = done_q;
  assign SpeedAck    = ack_q;
  assign SpeedErr    = err_q;
  assign CtrlBusy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_clk_switch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_clk_switch_ctrl
// Purpose  : Self-checking bench for sd_clk_switch_ctrl. Models the SD clock
//            mux, logs per-edge history, and derives expected event edges
//            from the logged clock/busy waveforms.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd_clk_switch_ctrl;

  localparam int INIT_EDGES = 4;
  localparam int STOP       = 64;
  localparam int SETTLE     = 64;
  localparam int TO         = 600;
  localparam int CW         = 20;
  localparam int HMAX       = 65536;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic SDLocalClk = 1'b0;
  logic SDBusy = 1'b0;
  logic SpeedReq = 1'b0;
  logic SpeedSel = 1'b0;
  logic SDClkSelect, SDClkEnable, InitDone, SpeedAck, SpeedErr, CtrlBusy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ph    = 0;

  // Per-edge history: inputs as seen by edge e, outputs as left by edge e.
  bit sdclk_h [HMAX];
  bit busy_h  [HMAX];
  bit sel_h   [HMAX];
  bit en_h    [HMAX];
  bit done_h  [HMAX];
  bit ack_h   [HMAX];
  bit err_h   [HMAX];
  bit cbusy_h [HMAX];

  sd_clk_switch_ctrl #(
    .INIT_EDGES   (INIT_EDGES),
    .STOP_CYCLES  (STOP),
    .SETTLE_CYCLES(SETTLE),
    .BUSY_TIMEOUT (TO),
    .CW           (CW)
  ) dut (
    .pll0_250MHz(clk),
    .reset      (reset),
    .SDLocalClk (SDLocalClk),
    .SDBusy     (SDBusy),
    .SpeedReq   (SpeedReq),
    .SpeedSel   (SpeedSel),
    .SDClkSelect(SDClkSelect),
    .SDClkEnable(SDClkEnable),
    .InitDone   (InitDone),
    .SpeedAck   (SpeedAck),
    .SpeedErr   (SpeedErr),
    .CtrlBusy   (CtrlBusy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cyc < HMAX) begin
      sdclk_h[cyc] = SDLocalClk;
      busy_h[cyc]  = SDBusy;
    end
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    if (cyc >= 1 && cyc <= HMAX) begin
      sel_h[cyc-1]   = SDClkSelect;
      en_h[cyc-1]    = SDClkEnable;
      done_h[cyc-1]  = InitDone;
      ack_h[cyc-1]   = SpeedAck;
      err_h[cyc-1]   = SpeedErr;
      cbusy_h[cyc-1] = CtrlBusy;
    end
  end

  // Behavioural SD clock mux: 10 MHz or ~400 kHz square wave by select.
  always @(negedge clk) begin
    int half;
    half = SDClkSelect ? 12 : 312;
    if (ph >= half - 1) begin
      SDLocalClk = ~SDLocalClk;
      ph = 0;
    end else begin
      ph = ph + 1;
    end
  end

  initial begin
    #(90000 * 10);
    $display("FAIL watchdog: simulation did not finish, cyc=%0d required <90000", cyc);
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic int first_low(input int from);
    for (int e = from; e < cyc && e < HMAX; e++)
      if (e >= 0 && !sdclk_h[e]) return e;
    return -1;
  endfunction

  function automatic int first_nobusy(input int from);
    for (int e = from; e < cyc && e < HMAX; e++)
      if (e >= 0 && !busy_h[e]) return e;
    return -1;
  endfunction

  task automatic test_reset(output int rl);
    reset = 1'b1;
    repeat (3) tick();
    total++; if (SDClkSelect !== 1'b0) begin bad++; $display("FAIL reset_sel: got %b required 0", SDClkSelect); end
    total++; if (SDClkEnable !== 1'b0) begin bad++; $display("FAIL reset_en: got %b required 0", SDClkEnable); end
    total++; if (InitDone !== 1'b0) begin bad++; $display("FAIL reset_done: got %b required 0", InitDone); end
    total++; if (SpeedAck !== 1'b0) begin bad++; $display("FAIL reset_ack: got %b required 0", SpeedAck); end
    total++; if (SpeedErr !== 1'b0) begin bad++; $display("FAIL reset_err: got %b required 0", SpeedErr); end
    total++; if (CtrlBusy !== 1'b1) begin bad++; $display("FAIL reset_busy: got %b required 1", CtrlBusy); end
    reset = 1'b0;
    rl = cyc - 1;
  endtask

  // Power-up burst: gate opens on first low, INIT_EDGES rises, closes on next low.
  task automatic test_init(input int rl);
    int lim, wend, e1, e4, e2, n, o_rise, o_fall, o_done, n_en, n_sel;
    lim = 0;
    while (!InitDone && lim < 8000) begin tick(); lim++; end
    total++; if (lim >= 8000) begin bad++; $display("FAIL init_timeout: InitDone=%b after %0d cycles required 1", InitDone, lim); end
    repeat (2) tick();
    wend = cyc - 1;
    e1 = first_low(rl + 1);
    e4 = -1; n = 0;
    if (e1 >= 0)
      for (int e = e1 + 1; e <= wend; e++) begin
        if (sdclk_h[e] && !sdclk_h[e-1]) n++;
        if (n == INIT_EDGES) begin e4 = e; break; end
      end
    e2 = (e4 >= 0) ? first_low(e4 + 1) : -1;
    o_rise = -1; o_fall = -1; o_done = -1; n_en = 0; n_sel = 0;
    for (int e = rl + 1; e <= wend; e++) begin
      if (o_rise < 0 && en_h[e]) o_rise = e;
      if (o_rise >= 0 && o_fall < 0 && e > o_rise && !en_h[e]) o_fall = e;
      if (o_done < 0 && done_h[e]) o_done = e;
      if (sdclk_h[e] && !sdclk_h[e-1] && en_h[e-1]) n_en++;
      if (sel_h[e]) n_sel++;
    end
    total++; if (o_rise !== e1) begin bad++; $display("FAIL init_open: edge %0d required %0d", o_rise, e1); end
    total++; if (o_fall !== e2) begin bad++; $display("FAIL init_close: edge %0d required %0d", o_fall, e2); end
    total++; if (o_done !== e2) begin bad++; $display("FAIL init_done: edge %0d required %0d", o_done, e2); end
    total++; if (n_en !== INIT_EDGES) begin bad++; $display("FAIL init_rises: %0d rises enabled required %0d", n_en, INIT_EDGES); end
    total++; if (n_sel !== 0) begin bad++; $display("FAIL init_sel: %0d cycles with select=1 required 0", n_sel); end
  endtask

  task automatic test_switch(input bit s, input int busy_len, input string nm);
    int rq, dr, k, lim, g1, g2, wend;
    int e_ack, e_err, e_sel, n_ack, n_err, f_ack, f_err, f_sel, n_en, n_bz;
    bit cur_sel, exp_sel, tmo;
    repeat ($urandom_range(0, 300)) tick();
    total++; if (CtrlBusy !== 1'b0) begin bad++; $display("FAIL %s idle_before: CtrlBusy=%b required 0", nm, CtrlBusy); end
    cur_sel  = SDClkSelect;
    SpeedSel = s;
    SpeedReq = 1'b1;
    SDBusy   = (busy_len > 0);
    rq = cyc;
    k = 0; lim = 0;
    while (!(SpeedAck || SpeedErr) && lim < 6000) begin
      tick(); k++; lim++;
      if (k >= busy_len) SDBusy = 1'b0;
      if (k >= 2) SpeedSel = 1'($urandom_range(0, 1));
    end
    total++; if (lim >= 6000) begin bad++; $display("FAIL %s done_timeout: no ack/err after %0d cycles", nm, lim); end
    SDBusy = 1'b0;
    repeat (2) tick();
    SpeedReq = 1'b0;
    dr = cyc;
    repeat (3) tick();
    wend = cyc - 1;
    // Reference: timing from logged busy/clock waveforms.
    tmo = 1'b1;
    for (int e = rq + 1; e <= rq + TO; e++) if (!busy_h[e]) tmo = 1'b0;
    if (s == cur_sel) begin
      e_ack = rq; e_err = -1; e_sel = -1;
    end else if (tmo) begin
      e_ack = -1; e_err = rq + TO; e_sel = -1;
    end else begin
      g1 = first_nobusy(rq + 1);
      g2 = first_low(g1 + 1);
      e_sel = g2 + STOP;
      e_ack = first_low(e_sel + SETTLE + 1);
      e_err = -1;
    end
    exp_sel = (e_sel >= 0) ? s : cur_sel;
    n_ack = 0; n_err = 0; f_ack = -1; f_err = -1; f_sel = -1; n_en = 0; n_bz = 0;
    for (int e = rq; e <= wend; e++) begin
      if (ack_h[e]) begin n_ack++; if (f_ack < 0) f_ack = e; end
      if (err_h[e]) begin n_err++; if (f_err < 0) f_err = e; end
      if (f_sel < 0 && sel_h[e] != sel_h[e-1]) f_sel = e;
      if (en_h[e] != en_h[e-1]) n_en++;
      if (e < dr && !cbusy_h[e]) n_bz++;
    end
    total++; if (n_ack !== ((e_ack >= 0) ? 1 : 0)) begin bad++; $display("FAIL %s ack_count: %0d required %0d", nm, n_ack, (e_ack >= 0) ? 1 : 0); end
    total++; if (f_ack !== e_ack) begin bad++; $display("FAIL %s ack_edge: %0d required %0d", nm, f_ack, e_ack); end
    total++; if (n_err !== ((e_err >= 0) ? 1 : 0)) begin bad++; $display("FAIL %s err_count: %0d required %0d", nm, n_err, (e_err >= 0) ? 1 : 0); end
    total++; if (f_err !== e_err) begin bad++; $display("FAIL %s err_edge: %0d required %0d", nm, f_err, e_err); end
    total++; if (f_sel !== e_sel) begin bad++; $display("FAIL %s sel_edge: %0d required %0d", nm, f_sel, e_sel); end
    total++; if (sel_h[wend] !== exp_sel) begin bad++; $display("FAIL %s sel_final: %b required %b", nm, sel_h[wend], exp_sel); end
    total++; if (n_en !== 0) begin bad++; $display("FAIL %s en_toggles: %0d required 0", nm, n_en); end
    total++; if (n_bz !== 0) begin bad++; $display("FAIL %s busy_held: %0d idle cycles during request required 0", nm, n_bz); end
    total++; if (cbusy_h[dr] !== 1'b0) begin bad++; $display("FAIL %s busy_release: CtrlBusy=%b required 0", nm, cbusy_h[dr]); end
  endtask

  task automatic test_speed_up();   test_switch(1'b1, 0, "speed_up");   endtask
  task automatic test_same_speed(); test_switch(SDClkSelect, $urandom_range(0, 50), "same_speed"); endtask
  task automatic test_busy_wait();  test_switch(~SDClkSelect, 500, "busy_wait"); endtask
  task automatic test_timeout();    test_switch(~SDClkSelect, TO + 50, "timeout"); endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++)
      test_switch(1'($urandom_range(0, 1)), $urandom_range(0, 200), "random");
  endtask

  // Reset during the stop window with a select change pending.
  task automatic test_reset_mid();
    int rq, lim, g2, rl, n_ack;
    repeat (50) tick();
    SpeedSel = ~SDClkSelect;
    SpeedReq = 1'b1;
    SDBusy   = 1'b0;
    rq = cyc; lim = 0; g2 = -1;
    while (lim < 2000) begin
      tick(); lim++;
      if (g2 < 0) g2 = first_low(rq + 2);
      if (g2 >= 0 && cyc - 1 >= g2 + 20) break;
    end
    total++; if (lim >= 2000) begin bad++; $display("FAIL mid_reach: stop window not reached in %0d cycles", lim); end
    reset = 1'b1;
    tick();
    total++; if (SDClkSelect !== 1'b0) begin bad++; $display("FAIL mid_sel: got %b required 0", SDClkSelect); end
    total++; if (SDClkEnable !== 1'b0) begin bad++; $display("FAIL mid_en: got %b required 0", SDClkEnable); end
    total++; if (InitDone !== 1'b0) begin bad++; $display("FAIL mid_done: got %b required 0", InitDone); end
    total++; if (CtrlBusy !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b required 1", CtrlBusy); end
    tick();
    reset = 1'b0;
    SpeedReq = 1'b0;
    rl = cyc - 1;
    test_init(rl);
    n_ack = 0;
    for (int e = rq; e < cyc; e++) if (ack_h[e]) n_ack++;
    total++; if (n_ack !== 0) begin bad++; $display("FAIL mid_ack: %0d acks required 0", n_ack); end
  endtask

  initial begin
    int rl;
    test_reset(rl);
    test_init(rl);
    test_speed_up();
    test_same_speed();
    test_busy_wait();
    test_random();
    test_timeout();
    test_same_speed();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
